// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encodings (identical to the state_dbg values), opcode/funct constants,
// ALU control codes and the ALUSrcB / PCSource mux encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_R_WB    = 4'd7,
        S_I_EXEC  = 4'd8,
        S_I_WB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b1110;
    localparam logic [3:0] ALU_SLT = 4'b1111;

    localparam logic [1:0] SRCB_RB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// mips_alu_decoder
// Combinational funct -> ALUCtrl mapping for R-type instructions.
// Ports:
//   funct    in  6  funct field latched at DECODE
//   alu_ctrl out 4  ALU operation code; unknown functs fall back to ADD
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_XOR:  alu_ctrl = ALU_XOR;
            FN_NOR:  alu_ctrl = ALU_NOR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM of the multi-cycle MIPS core. Sequences every
// instruction through FETCH/DECODE and its execute/writeback states and
// drives the datapath strobes for the current state.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   Op, Function, Zero      opcode, funct and ALU zero flag from datapath
//   IorD ... ALUCtrl        datapath control strobes (Moore on state,
//                           except PCSel in BRANCH which follows Zero)
//   illegal                 sticky flag, set when an unknown opcode halts
//   state_dbg               current state encoding
//   instr_retired           retired-instruction count, wraps at 2^CNT_W
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Function,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             PCSel,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUCtrl,
    output logic             illegal,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [3:0] r_alu_ctrl;

    mips_alu_decoder u_alu_dec (
        .funct    (funct_q),
        .alu_ctrl (r_alu_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FETCH;
            op_q          <= '0;
            funct_q       <= '0;
            illegal       <= 1'b0;
            instr_retired <= '0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q    <= Op;
                    funct_q <= Function;
                    case (Op)
                        OP_LW, OP_SW:     state <= S_MEM_ADR;
                        OP_R:             state <= S_R_EXEC;
                        OP_ADDI, OP_SLTI: state <= S_I_EXEC;
                        OP_BEQ, OP_BNE:   state <= S_BRANCH;
                        OP_J:             state <= S_JUMP;
                        default: begin
                            state   <= S_HALT;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADR: state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  state <= S_MEM_WB;
                S_R_EXEC:  state <= S_R_WB;
                S_I_EXEC:  state <= S_I_WB;
                // Every retiring state bumps the counter on its exit edge.
                S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                    state         <= S_FETCH;
                    instr_retired <= instr_retired + CNT_ONE;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    assign state_dbg = state;

    // Strobes are gated by reset so that an asynchronous reset in the
    // middle of MEM_WR / *_WB kills the write before the next edge, and
    // FETCH's strobes do not fire while reset is held.
    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        IRWrite  = 1'b0;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        PCSel    = 1'b0;
        PCSource = PCSRC_ALU;
        ALUSrcB  = SRCB_RB;
        ALUCtrl  = ALU_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    PCSel   = 1'b1;
                end
                S_DECODE:  ALUSrcB = SRCB_IMM_SH;
                S_MEM_ADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUCtrl = r_alu_ctrl;
                end
                S_R_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUCtrl = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_I_WB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUCtrl  = ALU_SUB;
                    PCSource = PCSRC_ALUOUT;
                    // Mealy: the branch decision follows Zero in the same cycle.
                    PCSel    = (op_q == OP_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCSource = PCSRC_JUMP;
                    PCSel    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic [5:0]  Function;
    logic        Zero;
    logic        IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA;
    logic        RegWrite, RegDst, PCSel, illegal;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUCtrl, state_dbg;
    logic [15:0] instr_retired;

    logic        w_IorD, w_MemRead, w_MemWrite, w_MemToReg, w_IRWrite, w_ALUSrcA;
    logic        w_RegWrite, w_RegDst, w_PCSel, w_illegal;
    logic [1:0]  w_PCSource, w_ALUSrcB;
    logic [3:0]  w_ALUCtrl, w_state;
    logic [2:0]  w_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;

    // Strobe order: IorD MemRead MemWrite MemToReg IRWrite ALUSrcA RegWrite
    // RegDst PCSel | PCSource | ALUSrcB | ALUCtrl
    localparam logic [16:0] ST_FETCH  = 17'b010010001_00_01_0110;
    localparam logic [16:0] ST_DECODE = 17'b000000000_00_11_0110;
    localparam logic [16:0] ST_MEMADR = 17'b000001000_00_10_0110;
    localparam logic [16:0] ST_MEMRD  = 17'b110000000_00_00_0110;
    localparam logic [16:0] ST_MEMWB  = 17'b000100100_00_00_0110;
    localparam logic [16:0] ST_MEMWR  = 17'b101000000_00_00_0110;
    localparam logic [16:0] ST_REXSUB = 17'b000001000_00_00_1110;
    localparam logic [16:0] ST_RWB    = 17'b000000110_00_00_0110;
    localparam logic [16:0] ST_IWB    = 17'b000000100_00_00_0110;
    localparam logic [16:0] ST_BR_T   = 17'b000001001_01_00_1110;
    localparam logic [16:0] ST_BR_N   = 17'b000001000_01_00_1110;
    localparam logic [16:0] ST_JUMP   = 17'b000000001_10_00_0110;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
        .illegal(illegal), .state_dbg(state_dbg), .instr_retired(instr_retired)
    );

    // Narrow counter instance to exercise wrap-around in a few cycles.
    mips_multicycle_ctrl #(.CNT_W(3)) dut_wrap (
        .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
        .IorD(w_IorD), .MemRead(w_MemRead), .MemWrite(w_MemWrite), .MemToReg(w_MemToReg),
        .IRWrite(w_IRWrite), .ALUSrcA(w_ALUSrcA), .RegWrite(w_RegWrite), .RegDst(w_RegDst),
        .PCSel(w_PCSel), .PCSource(w_PCSource), .ALUSrcB(w_ALUSrcB), .ALUCtrl(w_ALUCtrl),
        .illegal(w_illegal), .state_dbg(w_state), .instr_retired(w_cnt)
    );

    function automatic logic [16:0] strobes();
        return {IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite,
                RegDst, PCSel, PCSource, ALUSrcB, ALUCtrl};
    endfunction

    function automatic logic [12:0] strobe13();
        return {IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite,
                RegDst, PCSel, PCSource, ALUSrcB};
    endfunction

    function automatic logic [20:0] view();
        return {state_dbg, strobes()};
    endfunction

    function automatic logic [21:0] wrap_view();
        return {w_illegal, w_state, w_IorD, w_MemRead, w_MemWrite, w_MemToReg, w_IRWrite,
                w_ALUSrcA, w_RegWrite, w_RegDst, w_PCSel, w_PCSource, w_ALUSrcB, w_ALUCtrl};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #12;
        checks++;
        if ({state_dbg, strobe13()} !== 17'd0) begin
            errors++;
            $display("FAIL reset_strobes: got %h want %h", {state_dbg, strobe13()}, 17'd0);
        end
        checks++;
        if ({illegal, instr_retired, w_cnt} !== 20'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h want %h", {illegal, instr_retired, w_cnt}, 20'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lw();
        Op = 6'b100011; #1;
        checks++;
        if (view() !== {4'd0, ST_FETCH}) begin
            errors++; $display("FAIL lw_fetch: got %h want %h", view(), {4'd0, ST_FETCH});
        end
        @(negedge clk);
        checks++;
        if (view() !== {4'd1, ST_DECODE}) begin
            errors++; $display("FAIL lw_decode: got %h want %h", view(), {4'd1, ST_DECODE});
        end
        @(negedge clk);
        Op = 6'b111111; #1;
        checks++;
        if (view() !== {4'd2, ST_MEMADR}) begin
            errors++; $display("FAIL lw_memadr: got %h want %h", view(), {4'd2, ST_MEMADR});
        end
        @(negedge clk);
        checks++;
        if (view() !== {4'd3, ST_MEMRD}) begin
            errors++; $display("FAIL lw_memrd: got %h want %h", view(), {4'd3, ST_MEMRD});
        end
        @(negedge clk);
        checks++;
        if ({view(), instr_retired} !== {4'd4, ST_MEMWB, exp_cnt}) begin
            errors++; $display("FAIL lw_memwb: got %h want %h", {view(), instr_retired}, {4'd4, ST_MEMWB, exp_cnt});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
            errors++; $display("FAIL lw_retire: got %h want %h", {state_dbg, instr_retired}, {4'd0, exp_cnt});
        end
    endtask

    task automatic test_sw();
        Op = 6'b101011;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (view() !== {4'd2, ST_MEMADR}) begin
            errors++; $display("FAIL sw_memadr: got %h want %h", view(), {4'd2, ST_MEMADR});
        end
        @(negedge clk);
        checks++;
        if (view() !== {4'd5, ST_MEMWR}) begin
            errors++; $display("FAIL sw_memwr: got %h want %h", view(), {4'd5, ST_MEMWR});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
            errors++; $display("FAIL sw_retire: got %h want %h", {state_dbg, instr_retired}, {4'd0, exp_cnt});
        end
    endtask

    task automatic test_r_sub();
        Op = 6'b000000; Function = 6'b100010;
        @(negedge clk);
        @(negedge clk);
        Function = 6'b100100; #1;
        checks++;
        if (view() !== {4'd6, ST_REXSUB}) begin
            errors++; $display("FAIL r_sub_exec: got %h want %h", view(), {4'd6, ST_REXSUB});
        end
        @(negedge clk);
        checks++;
        if (view() !== {4'd7, ST_RWB}) begin
            errors++; $display("FAIL r_sub_wb: got %h want %h", view(), {4'd7, ST_RWB});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
            errors++; $display("FAIL r_sub_retire: got %h want %h", {state_dbg, instr_retired}, {4'd0, exp_cnt});
        end
    endtask

    task automatic test_alu_funcs();
        logic [5:0] fn [7] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b101010, 6'b000000};
        logic [3:0] ac [7] = '{4'b0110, 4'b0000, 4'b0001, 4'b0010,
                               4'b0011, 4'b1111, 4'b0110};
        for (int i = 0; i < 7; i++) begin
            Op = 6'b000000; Function = fn[i];
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({state_dbg, ALUCtrl} !== {4'd6, ac[i]}) begin
                errors++;
                $display("FAIL alu_funct_%0d: got %h want %h", i, {state_dbg, ALUCtrl}, {4'd6, ac[i]});
            end
            @(negedge clk);
            @(negedge clk);
            exp_cnt++;
        end
        checks++;
        if (instr_retired !== exp_cnt) begin
            errors++; $display("FAIL alu_funcs_count: got %0d want %0d", instr_retired, exp_cnt);
        end
    endtask

    task automatic test_i_type();
        logic [5:0] ops [2] = '{6'b001000, 6'b001010};
        logic [3:0] ac  [2] = '{4'b0110, 4'b1111};
        for (int i = 0; i < 2; i++) begin
            Op = ops[i];
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (view() !== {4'd8, 9'b000001000, 2'b00, 2'b10, ac[i]}) begin
                errors++;
                $display("FAIL i_exec_%0d: got %h want %h", i, view(), {4'd8, 9'b000001000, 2'b00, 2'b10, ac[i]});
            end
            @(negedge clk);
            checks++;
            if (view() !== {4'd9, ST_IWB}) begin
                errors++; $display("FAIL i_wb_%0d: got %h want %h", i, view(), {4'd9, ST_IWB});
            end
            @(negedge clk);
            exp_cnt++;
            checks++;
            if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
                errors++; $display("FAIL i_retire_%0d: got %h want %h", i, {state_dbg, instr_retired}, {4'd0, exp_cnt});
            end
        end
    endtask

    task automatic test_branch();
        // BEQ: taken when Zero=1, then Zero flips within the same cycle.
        Op = 6'b000100; Zero = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (view() !== {4'd10, ST_BR_T}) begin
            errors++; $display("FAIL beq_zero1: got %h want %h", view(), {4'd10, ST_BR_T});
        end
        Zero = 1'b0; #1;
        checks++;
        if (view() !== {4'd10, ST_BR_N}) begin
            errors++; $display("FAIL beq_zero0: got %h want %h", view(), {4'd10, ST_BR_N});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
            errors++; $display("FAIL beq_retire: got %h want %h", {state_dbg, instr_retired}, {4'd0, exp_cnt});
        end
        // BNE: taken when Zero=0.
        Op = 6'b000101; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (view() !== {4'd10, ST_BR_T}) begin
            errors++; $display("FAIL bne_zero0: got %h want %h", view(), {4'd10, ST_BR_T});
        end
        Zero = 1'b1; #1;
        checks++;
        if (view() !== {4'd10, ST_BR_N}) begin
            errors++; $display("FAIL bne_zero1: got %h want %h", view(), {4'd10, ST_BR_N});
        end
        @(negedge clk);
        exp_cnt++;
        Zero = 1'b0;
        checks++;
        if ({state_dbg, instr_retired} !== {4'd0, exp_cnt}) begin
            errors++; $display("FAIL bne_retire: got %h want %h", {state_dbg, instr_retired}, {4'd0, exp_cnt});
        end
    endtask

    task automatic test_jump();
        Op = 6'b000010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (view() !== {4'd11, ST_JUMP}) begin
            errors++; $display("FAIL jump_state: got %h want %h", view(), {4'd11, ST_JUMP});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({view(), instr_retired} !== {4'd0, ST_FETCH, exp_cnt}) begin
            errors++; $display("FAIL jump_retire: got %h want %h", {view(), instr_retired}, {4'd0, ST_FETCH, exp_cnt});
        end
    endtask

    task automatic test_reset_mid_write();
        Op = 6'b101011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({state_dbg, MemWrite} !== {4'd5, 1'b1}) begin
            errors++; $display("FAIL midwr_before: got %h want %h", {state_dbg, MemWrite}, {4'd5, 1'b1});
        end
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        checks++;
        if ({state_dbg, strobe13(), instr_retired} !== {4'd0, 13'd0, exp_cnt}) begin
            errors++;
            $display("FAIL midwr_async_reset: got %h want %h", {state_dbg, strobe13(), instr_retired}, {4'd0, 13'd0, exp_cnt});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_halt();
        Op = 6'b111111;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({illegal, state_dbg, strobe13(), instr_retired} !== {1'b1, 4'd15, 13'd0, exp_cnt}) begin
                errors++;
                $display("FAIL halt_cycle_%0d: got %h want %h", i, {illegal, state_dbg, strobe13(), instr_retired},
                         {1'b1, 4'd15, 13'd0, exp_cnt});
            end
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({illegal, state_dbg} !== {1'b0, 4'd0}) begin
            errors++; $display("FAIL halt_reset_clear: got %h want %h", {illegal, state_dbg}, {1'b0, 4'd0});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            Op = 6'b000010;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            exp_cnt++;
            if (i == 6) begin
                checks++;
                if (w_cnt !== 3'd7) begin
                    errors++; $display("FAIL wrap_at_max: got %0d want %0d", w_cnt, 3'd7);
                end
            end
        end
        checks++;
        if ({w_cnt, instr_retired} !== {3'd0, exp_cnt}) begin
            errors++; $display("FAIL wrap_to_zero: got %h want %h", {w_cnt, instr_retired}, {3'd0, exp_cnt});
        end
        checks++;
        if (wrap_view() !== {1'b0, 4'd0, ST_FETCH}) begin
            errors++; $display("FAIL wrap_inst_state: got %h want %h", wrap_view(), {1'b0, 4'd0, ST_FETCH});
        end
    endtask

    initial begin
        reset = 1'b1;
        Op = 6'd0;
        Function = 6'd0;
        Zero = 1'b0;
        exp_cnt = '0;
        test_reset();
        test_lw();
        test_sw();
        test_r_sub();
        test_alu_funcs();
        test_i_type();
        test_branch();
        test_jump();
        test_reset_mid_write();
        test_lw();
        test_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core; the counterpart of the datapath.
- Consumes Op, Function and Zero from the datapath and drives every datapath control strobe cycle by cycle.
- Also reports an illegal-opcode halt, the current state, and a count of retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  opcode from instruction register
Function  in  6  funct field from datapath
Zero  in  1  ALU result == 0, combinational, same cycle
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
MemToReg  out  1  register-file write data: 1=MDR, 0=ALUOut
IRWrite  out  1  instruction register load
ALUSrcA  out  1  0=PC, 1=RA
RegWrite  out  1  register-file write
RegDst  out  1  1=rd, 0=rt
PCSel  out  1  PC load enable
PCSource  out  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcB  out  2  00=RB, 01=const 4, 10=sext imm, 11=sext imm<<2
ALUCtrl  out  4  0000 AND, 0001 OR, 0010 XOR, 0011 NOR, 0110 ADD, 1110 SUB, 1111 SLT
illegal  out  1  sticky halt flag
state_dbg  out  4  current state encoding
instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, active-high) sets: state=FETCH, op_q=0, funct_q=0, illegal=0, instr_retired=0.
- While reset is high, all strobes are forced to 0. MemWrite and RegWrite are never asserted during reset.
- Strobes are Moore-decoded from the state, except PCSel in BRANCH, which is Mealy on Zero.
- Unlisted strobes are 0. ALUCtrl defaults to ADD.
- Decoded opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, ADDI=001000, SLTI=001010.
- Decoded functs: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010.
- Unknown funct decodes to ADD (not illegal).
- States and per-state behaviour:
  - FETCH: MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCSel. Next state: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Latches op_q<=Op and funct_q<=Function.
  - DECODE next state by Op: LW/SW→MEM_ADR, R→R_EXEC, ADDI/SLTI→I_EXEC, BEQ/BNE→BRANCH, J→JUMP, else→HALT.
  - MEM_ADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state: MEM_RD if op_q=LW, else MEM_WR.
  - MEM_RD: IorD=1, MemRead. Next state: MEM_WB.
  - MEM_WB: MemToReg, RegWrite, RegDst=0. Retire. Next state: FETCH.
  - MEM_WR: IorD=1, MemWrite. Retire. Next state: FETCH.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtrl=alu_dec(funct_q). Next state: R_WB.
  - R_WB: RegDst=1, RegWrite, MemToReg=0. Retire. Next state: FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADD (ADDI) or SLT (SLTI). Next state: I_WB.
  - I_WB: RegDst=0, RegWrite. Retire. Next state: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01. PCSel=Zero for BEQ, PCSel=~Zero for BNE. Retire. Next state: FETCH.
  - JUMP: PCSource=10, PCSel. Retire. Next state: FETCH.
  - HALT: all strobes 0; illegal=1. Stays in HALT until reset.
- Latency in cycles, FETCH through retire: LW 5, SW 4, R 4, ADDI/SLTI 4, BEQ/BNE 3, J 3.
- Retire: instr_retired increments by 1 on the clock edge leaving the retiring state. It wraps modulo 2^CNT_W and does not count HALT.
- Changes on Op/Function after DECODE have no effect; only op_q and funct_q are used.
- Reset asserted mid-instruction returns to FETCH immediately and asynchronously. The pending write strobe is suppressed.
- state_dbg encoding: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, HALT=15.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum, using the state_dbg encodings above;
  - opcode and funct constants;
  - ALUCtrl codes;
  - ALUSrcB and PCSource encodings.
- Sub-module mips_alu_decoder: combinational funct→ALUCtrl mapping, instantiated once.

Test Plan:
- Reset mid-MEM_WR (MemWrite=1), async → MemWrite drops before the next edge; state_dbg=0; instr_retired=0.
- Op=100011 (LW) → states 0,1,2,3,4,0. IorD=1+MemRead in state 3; MemToReg+RegWrite in state 4; instr_retired=1.
- Op=000000, Function=100010 (sub) → ALUCtrl=1110 in R_EXEC; RegDst=1+RegWrite in R_WB; 4 cycles total.
- BEQ with Zero=1 → PCSel=1, PCSource=01 in BRANCH. Repeat with Zero=0 → PCSel=0. BNE with Zero=0 → PCSel=1.
- Op=000010 (J) → JUMP with PCSource=10, PCSel=1; back to FETCH after 3 cycles.
- Op=111111 → HALT: illegal=1, all strobes 0 for 20 cycles, counter frozen; reset clears illegal. Separately, preload 16'hFFFF + 1 retire → 0.
